// File: rtl/router_pkt_source.sv
// rtl/router_pkt_source.sv - Router upstream packet generator (header, payload, parity); option ROUTER_SRC_BADPAR_EN
module router_pkt_source #(
    parameter int DATA_W     = 3,
    parameter int LEN_W      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
`ifdef ROUTER_SRC_BADPAR_EN
    input  logic              cmd_corrupt,
`endif
    input  logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_valid,
    output logic              active,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    localparam logic [2:0] GAP_LOAD = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

    logic [2:0]        state_q, state_d;
    logic [1:0]        addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic              corrupt_q, corrupt_d;
    logic [2:0]        gap_q, gap_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        word_d    = word_q;
        par_d     = par_q;
        corrupt_d = corrupt_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    word_d  = cmd_seed;
                    par_d   = '0;
`ifdef ROUTER_SRC_BADPAR_EN
                    corrupt_d = cmd_corrupt;
`else
                    corrupt_d = 1'b0;
`endif
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    par_d   = par_q ^ DATA_W'(addr_q);
                    state_d = (rem_q != '0) ? S_PAYLOAD : S_PARITY;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    par_d  = par_q ^ word_q;
                    word_d = word_q + DATA_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    gap_d   = GAP_LOAD;
                    state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        data_d   = '0;
        valid_d  = 1'b0;
        active_d = 1'b0;
        ready_d  = (state_d == S_IDLE);
        case (state_d)
            S_HEADER: begin
                data_d   = DATA_W'(addr_d);
                valid_d  = 1'b1;
                active_d = 1'b1;
            end
            S_PAYLOAD: begin
                data_d   = word_d;
                valid_d  = 1'b1;
                active_d = 1'b1;
            end
            S_PARITY: begin
                data_d   = corrupt_d ? ~par_d : par_d;
                active_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            word_q    <= '0;
            par_q     <= '0;
            corrupt_q <= 1'b0;
            gap_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            word_q    <= word_d;
            par_q     <= par_d;
            corrupt_q <= corrupt_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_ready = ready_q;
    assign data_out  = data_q;
    assign pkt_valid = valid_q;
    assign active    = active_q;
    assign done      = done_q;
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_router_pkt_source.sv
// tb/tb_router_pkt_source.sv - Bench for router_pkt_source against a word-list packet model
module tb_router_pkt_source;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_addr = '0;
    logic [3:0] cmd_len = '0;
    logic [2:0] cmd_seed = '0;
    logic       cmd_corrupt = 1'b0;
    logic       busy = 1'b0;
    logic [2:0] data_out;
    logic       pkt_valid;
    logic       active;
    logic       done;
    logic [7:0] pkt_count;

    int         checks = 0;
    int         errors = 0;
    int         done_seen = 0;
    logic [7:0] exp_cnt = '0;

    router_pkt_source dut (
        .clock     (clock),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_seed  (cmd_seed),
`ifdef ROUTER_SRC_BADPAR_EN
        .cmd_corrupt (cmd_corrupt),
`endif
        .busy      (busy),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .active    (active),
        .done      (done),
        .pkt_count (pkt_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        busy = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clock);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_valid", 32'(pkt_valid), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(pkt_count), 0);
        resetn = 1'b1;
        exp_cnt = '0;
        @(negedge clock);
    endtask

    // Expected packet: header, seed+i payload words, xor of everything before as parity.
    task automatic build(input logic [1:0] a, input logic [3:0] l, input logic [2:0] s,
                         input logic bad, output logic [2:0] words[$]);
        logic [2:0] par;
        words = {};
        words.push_back({1'b0, a});
        for (int i = 0; i < int'(l); i++) words.push_back(3'((int'(s) + i) % 8));
        par = '0;
        foreach (words[i]) par ^= words[i];
        words.push_back(bad ? ~par : par);
    endtask

    task automatic issue(input logic [1:0] a, input logic [3:0] l, input logic [2:0] s, input logic bad);
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_addr = a;
        cmd_len = l;
        cmd_seed = s;
        cmd_corrupt = bad;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [1:0] a, input logic [3:0] l, input logic [2:0] s,
                            input logic bad, input int hold_idx, input int hold_n, input bit rnd);
        logic [2:0] words[$];
        int hold;
        build(a, l, s, bad, words);
        issue(a, l, s, bad);
        foreach (words[i]) begin
            hold = (i == hold_idx) ? hold_n : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int h = 0; h <= hold; h++) begin
                chk($sformatf("word%0d_data", i), 32'(data_out), 32'(words[i]));
                chk($sformatf("word%0d_valid", i), 32'(pkt_valid), (i < words.size() - 1) ? 1 : 0);
                chk($sformatf("word%0d_active", i), 32'(active), 1);
                chk($sformatf("word%0d_done", i), 32'(done), 0);
                busy = (h < hold);
                @(negedge clock);
            end
        end
        busy = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("done_pulse", 32'(done), 1);
        chk("count", 32'(pkt_count), 32'(exp_cnt));
        chk("gap_valid", 32'(pkt_valid), 0);
        chk("gap_data", 32'(data_out), 0);
        chk("gap_active", 32'(active), 0);
        chk("gap_ready", 32'(cmd_ready), 0);
        @(negedge clock);
        chk("done_clear", 32'(done), 0);
        chk("ready_back", 32'(cmd_ready), 1);
    endtask

    initial begin
        int done_base;
        logic [2:0] lit;

        do_reset();

        // Reset mid-packet while the second payload word is on the bus
        issue(2'd1, 4'd5, 3'd3, 1'b0);
        chk("mid_hdr", 32'(data_out), 1);
        @(negedge clock);
        chk("mid_p0", 32'(data_out), 3);
        @(negedge clock);
        chk("mid_p1", 32'(data_out), 4);
        resetn = 1'b0;
        #1;
        chk("abort_valid", 32'(pkt_valid), 0);
        chk("abort_data", 32'(data_out), 0);
        chk("abort_active", 32'(active), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_count", 32'(pkt_count), 0);
        chk("abort_ready", 32'(cmd_ready), 1);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Basic packet with fixed expected words
        issue(2'd1, 4'd3, 3'd2, 1'b0);
        lit = 3'b001; chk("basic_hdr", 32'(data_out), 32'(lit)); chk("basic_hdr_v", 32'(pkt_valid), 1);
        @(negedge clock);
        lit = 3'b010; chk("basic_p0", 32'(data_out), 32'(lit));
        @(negedge clock);
        lit = 3'b011; chk("basic_p1", 32'(data_out), 32'(lit));
        @(negedge clock);
        lit = 3'b100; chk("basic_p2", 32'(data_out), 32'(lit)); chk("basic_p2_v", 32'(pkt_valid), 1);
        @(negedge clock);
`ifdef ROUTER_SRC_BADPAR_EN
        lit = 3'b100;
`else
        lit = 3'b100;
`endif
        chk("basic_par", 32'(data_out), 32'(lit)); chk("basic_par_v", 32'(pkt_valid), 0);
        @(negedge clock);
        chk("basic_done", 32'(done), 1);
        chk("basic_count", 32'(pkt_count), 1);
        chk("basic_ready_gap", 32'(cmd_ready), 0);
        @(negedge clock);
        chk("basic_ready", 32'(cmd_ready), 1);
        exp_cnt = 8'd1;

        // Wrap, zero length, back-pressure on second payload word
        send_pkt(2'd0, 4'd4, 3'd6, 1'b0, -1, 0, 1'b0);
        send_pkt(2'd2, 4'd0, 3'd5, 1'b0, -1, 0, 1'b0);
        send_pkt(2'd1, 4'd3, 3'd2, 1'b0, 2, 3, 1'b0);
        send_pkt(2'd3, 4'd15, 3'd7, 1'b0, 0, 2, 1'b0);
`ifdef ROUTER_SRC_BADPAR_EN
        send_pkt(2'd1, 4'd3, 3'd2, 1'b1, -1, 0, 1'b0);
`endif

        // Randomized packets with random back-pressure
        for (int n = 0; n < 25; n++) begin
            send_pkt(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom),
`ifdef ROUTER_SRC_BADPAR_EN
                     1'($urandom),
`else
                     1'b0,
`endif
                     -1, 0, 1'b1);
        end

        // Counter wrap over 256 zero-length packets
        do_reset();
        done_base = done_seen;
        for (int n = 0; n < 256; n++) send_pkt(2'(n % 4), 4'd0, 3'd0, 1'b0, -1, 0, 1'b0);
        chk("wrap_count", 32'(pkt_count), 0);
        chk("wrap_done_pulses", 32'(done_seen - done_base), 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/router_pkt_source.md
Name: router_pkt_source

Overview:
- Upstream packet generator that drives the router's input side: data_in, pkt_valid, and the busy back-pressure input.
- Takes one command per packet (destination address, payload length, payload seed).
- Serialises each packet as header word, then payload words, then parity word, using the router's pkt_valid framing.
- Used as the on-chip stimulus stage ahead of router_top, and as a reusable driver for bench and bring-up.

Parameters:
- DATA_W, 3, router data word width.
- LEN_W, 4, width of cmd_len; up to 2^LEN_W-1 payload words.
- GAP_CYCLES, 1, idle cycles forced between packets (pkt_valid low), range 0..7.
- CNT_W, 8, width of the sent-packet counter.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  source can accept a command.
- cmd_addr  in  2  destination port (0..2; 3 is sent unchanged to exercise router drop).
- cmd_len  in  LEN_W  payload word count.
- cmd_seed  in  DATA_W  first payload word.
- busy  in  1  router back-pressure; word is held while high.
- data_out  out  DATA_W  to router data_in.
- pkt_valid  out  1  to router pkt_valid.
- active  out  1  packet in flight.
- done  out  1  one-cycle pulse when the parity word is consumed.
- pkt_count  out  CNT_W  packets completed, wraps.

Behaviour:
- Clocking and reset:
  - One clock (clock); reset is asynchronous and active-low (resetn).
  - Reset values: state=IDLE, data_out=0, pkt_valid=0, active=0, done=0, pkt_count=0, cmd_ready=1.
- Word transfer:
  - A word is consumed on a rising clock edge where state is HEADER, PAYLOAD or PARITY and busy=0.
  - While busy=1, data_out, pkt_valid and state are frozen.
- State machine:
  - IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch addr/len/seed and init parity register to 0. Next state is HEADER.
  - HEADER: data_out={1'b0, addr} (upper bits zero for DATA_W>3), pkt_valid=1. On consume: parity ^= header. Go to PAYLOAD if len>0, else PARITY.
  - PAYLOAD: data_out=word counter, starting at seed, +1 mod 2^DATA_W per consumed word (wraps). pkt_valid=1. On consume: parity ^= word, remaining--. Go to PARITY when the last word is consumed.
  - PARITY: data_out=parity register, pkt_valid=0. On consume: done=1 for that cycle, pkt_count+=1 (wraps). Go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: pkt_valid=0, data_out=0. Count GAP_CYCLES, then IDLE. busy is ignored here.
- Output timing:
  - active=1 in HEADER/PAYLOAD/PARITY.
  - cmd_ready=1 only in IDLE. No command queuing.
  - Latency: header appears on data_out one cycle after command accept.
- Boundary cases:
  - cmd_len=0 produces header then parity (parity = header).
  - busy asserted on the same edge as a word would be consumed: the word is not consumed.
  - cmd_valid while not ready is ignored; cmd_* must be held by the requester.
  - resetn low mid-packet aborts at once: outputs return to reset values, no done, and the partial packet is not counted.
- All outputs are registered.

Optional Feature:
- Macro ROUTER_SRC_BADPAR_EN.
- Defined:
  - Adds input port cmd_corrupt (1 bit), latched with the command.
  - When latched high, the parity word is sent bitwise inverted.
  - done and pkt_count behave normally.
  - Purpose: exercise the router err output.
- Undefined:
  - Port is absent; parity is always correct.

Test Plan:
- Basic packet: reset, GAP_CYCLES=1, busy=0, cmd addr=1 len=3 seed=2.
  - Response: data_out/pkt_valid sequence 001/1, 010/1, 011/1, 100/1, then parity 100/0.
  - done pulses on the parity cycle; pkt_count=1; cmd_ready returns 2 cycles after parity.
- Wrap and zero length: seed=6 len=4 gives payload 6,7,0,1. A follow-up cmd addr=2 len=0 gives 010/1 then 010/0.
- Back-pressure: busy=1 for 3 cycles while the second payload word is driven.
  - Response: that word is held unchanged for 3 extra cycles; the remaining sequence and parity are identical to the basic case.
- Reset mid-packet: resetn low during PAYLOAD.
  - Response: pkt_valid=0, data_out=0, active=0 asynchronously; pkt_count unchanged; the next command transmits normally.
- Counter wrap: 256 back-to-back len=0 packets with CNT_W=8 → pkt_count=0; 256 done pulses.
- ROUTER_SRC_BADPAR_EN with cmd_corrupt=1, addr=1 len=3 seed=2 → parity word 011 instead of 100.
